// File: rtl/onehot_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_encoder_pipe
//  Brief    : Registered one-hot to binary encoder with valid/ready handshake,
//             legality check (strict or lowest-bit priority) and a saturating
//             error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_encoder_pipe #(
    parameter int N        = 10,
    parameter int PRIORITY = 0,
    parameter int CNT_W    = 8,
    localparam int W       = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_code,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [W-1:0]     w_lsb_code;
    logic             w_any;
    logic             w_multi;
    logic [W-1:0]     w_code;
    logic             w_err;
    logic             w_accept;
    logic             w_out_ev;

    logic             r_out_valid;
    logic [W-1:0]     r_out_code;
    logic             r_out_err;
    logic [CNT_W-1:0] r_err_cnt;

    // Descending scan so the lowest set bit is the last (winning) write.
    always_comb begin
        w_lsb_code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_data[i]) begin
                w_lsb_code = W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign w_any   = |in_data;
    assign w_multi = |(in_data & (in_data - N'(1)));

    generate
        if (PRIORITY != 0) begin : g_prio
            assign w_err  = ~w_any;
            assign w_code = w_lsb_code;
        end else begin : g_strict
            assign w_err  = ~w_any | w_multi;
            assign w_code = w_err ? '0 : w_lsb_code;
        end
    endgenerate

    assign in_ready = ~rst & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_out_ev = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_code;
            r_out_err   <= w_err;
        end else if (w_out_ev) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != c_cnt_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_encoder_pipe
//  Brief    : Scoreboard bench; three DUT configurations driven in lockstep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        clr_cnt = 1'b0;
    logic        mon_en = 1'b0;

    logic        ov [3];
    logic        ir [3];
    logic [3:0]  oc [3];
    logic        oe [3];
    logic [7:0]  ec [3];
    logic [7:0]  ec_a;
    logic [3:0]  ec_b;
    logic [1:0]  ec_c;

    int errors = 0;
    int checks = 0;

    // Per-instance configuration: 0 = N10 strict, 1 = N16 priority, 2 = N10 strict CNT_W=2
    int cfg_n    [3] = '{10, 16, 10};
    int cfg_prio [3] = '{0, 1, 0};
    int cfg_max  [3] = '{255, 15, 3};

    logic [4:0] sb [3][$];
    logic [4:0] exp_reg [3];
    int         exp_cnt [3];

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.N(10), .PRIORITY(0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data[9:0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_code(oc[0]), .out_err(oe[0]), .clr_cnt(clr_cnt), .err_cnt(ec_a)
    );
    onehot_encoder_pipe #(.N(16), .PRIORITY(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_code(oc[1]), .out_err(oe[1]), .clr_cnt(clr_cnt), .err_cnt(ec_b)
    );
    onehot_encoder_pipe #(.N(10), .PRIORITY(0), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data[9:0]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_code(oc[2]), .out_err(oe[2]), .clr_cnt(clr_cnt), .err_cnt(ec_c)
    );

    assign ec[0] = ec_a;
    assign ec[1] = {4'b0, ec_b};
    assign ec[2] = {6'b0, ec_c};

    // Reference encode: returns {err, code} from bit population of the low n bits.
    function automatic logic [4:0] enc(input logic [15:0] d, input int n, input int prio);
        int cnt = 0;
        int low = -1;
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin
                cnt++;
                if (low < 0) low = i;
            end
        end
        if (cnt == 0) return 5'h10;
        if (cnt > 1 && prio == 0) return 5'h10;
        return {1'b0, 4'(low)};
    endfunction

    task automatic chk(input bit ok, input string name, input int k, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0d required=%0d at %0t", name, k, act, req, $time);
        end
    endtask

    // Monitor / scoreboard: check current outputs, then advance the model over the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                bit       exp_ready;
                bit       acc;
                logic [4:0] e;
                exp_ready = !rst && (sb[k].size() == 0 || out_ready);
                chk(ov[k] == (sb[k].size() != 0), "out_valid", k, int'(ov[k]), int'(sb[k].size() != 0));
                chk(ir[k] == exp_ready, "in_ready", k, int'(ir[k]), int'(exp_ready));
                chk({oe[k], oc[k]} == exp_reg[k], "out_reg", k, int'({oe[k], oc[k]}), int'(exp_reg[k]));
                chk(int'(ec[k]) == exp_cnt[k], "err_cnt", k, int'(ec[k]), exp_cnt[k]);
                if (ov[k] && sb[k].size() != 0)
                    chk({oe[k], oc[k]} == sb[k][0], "scoreboard", k, int'({oe[k], oc[k]}), int'(sb[k][0]));

                if (rst) begin
                    sb[k].delete();
                    exp_reg[k] = '0;
                    exp_cnt[k] = 0;
                end else begin
                    acc = in_valid && exp_ready;
                    if (sb[k].size() != 0 && out_ready) void'(sb[k].pop_front());
                    e = enc(in_data, cfg_n[k], cfg_prio[k]);
                    if (acc) begin
                        sb[k].push_back(e);
                        exp_reg[k] = e;
                    end
                    if (clr_cnt) exp_cnt[k] = 0;
                    else if (acc && e[4] && exp_cnt[k] < cfg_max[k]) exp_cnt[k]++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!ir[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(n < 50, "handshake_timeout", 0, n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc_prev;
        for (int k = 0; k < 3; k++) begin
            exp_reg[k] = '0;
            exp_cnt[k] = 0;
        end
        // Reset with a pending word that must not be taken
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0004;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // One-hot sweep, back to back
        for (int i = 0; i < 10; i++) send(16'(1 << i));
        idle(2);

        // Illegal words, then priority-mode words
        send(16'h0000);
        send(16'h000C);
        idle(2);
        send(16'h000C);
        send(16'h0000);
        idle(2);

        // Backpressure: hold code 5, offer bit 8, release after a few stalls
        out_ready = 1'b0;
        send(16'h0020);
        fork
            send(16'h0100);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(3);

        // Saturation, then clear coinciding with an illegal accept
        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0000);
        clr_cnt = 1'b1;
        send(16'h0300);
        clr_cnt = 1'b0;
        idle(2);

        // Random traffic with random backpressure, clears and occasional reset
        acc_prev = 1'b1;
        for (int t = 0; t < 600; t++) begin
            if (acc_prev || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       in_data = 16'(1 << $urandom_range(0, 15));
                    1:       in_data = 16'h0000;
                    2:       in_data = 16'(1 << $urandom_range(0, 9));
                    default: in_data = 16'($urandom);
                endcase
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr_cnt   = ($urandom_range(0, 30) == 0);
            rst       = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            acc_prev = in_valid && ir[0];
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        idle(4);
        for (int k = 0; k < 3; k++)
            chk(sb[k].size() == 0, "drain", k, sb[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_encoder_pipe.md
# onehot_encoder_pipe

Registered, parametrised one-hot-to-binary encoder with valid/ready handshaking on both sides, one-hot legality checking and a saturating error counter. It is the generalised successor to our fixed 10-line decimal-to-BCD encoder and sits between one-hot request/select sources (keypads, arbiter grants, decoded state vectors) and binary-indexed consumers. With the default parameters and strict mode, the code mapping matches the 10-line encoder. Illegal inputs are now flagged rather than silently mapped to 0.

## Interface
- N, 10: input width in lines, N >= 2.
- PRIORITY, 0: 0 = strict one-hot check; 1 = lowest-set-bit priority encode.
- CNT_W, 8: error counter width, CNT_W >= 1.
- W (localparam, not overridable): output code width, max(1, $clog2(N)).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept; in_ready = !rst && (!out_valid || out_ready).
- in_data  in  N  one-hot input; bit i represents value i.
- out_valid  out  1  out_code/out_err hold a result.
- out_ready  in  1  consumer accepts the result.
- out_code  out  W  encoded index.
- out_err  out  1  input was illegal for the selected mode.
- clr_cnt  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of accepted illegal inputs.

## Operation
- Accept event: the rising edge with in_valid && in_ready. Output event: the rising edge with out_valid && out_ready.
- Single output register stage:
  - On accept, out_code and out_err load from the encode of in_data, and out_valid sets.
  - On an output event with no accept, out_valid clears. out_code and out_err hold their last values.
  - Accept and output event on the same edge: the register reloads with the new word and out_valid stays 1.
- Strict mode (PRIORITY=0):
  - Exactly one bit i set: code = i, err = 0.
  - Zero bits set, or more than one: code = 0, err = 1.
- Priority mode (PRIORITY=1):
  - code = index of the lowest set bit. Multiple bits set is legal (err = 0).
  - Zero bits set: code = 0, err = 1.
- Encoding is combinational on in_data. in_data is ignored when no accept occurs.
- err_cnt:
  - Increments by 1 on each accept whose encode err = 1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt sets it to 0 at the next edge and takes priority over a same-cycle increment.
- Output stability: while out_valid && !out_ready, out_code and out_err must not change (standard valid/ready rule). Upstream must likewise hold in_data stable while in_valid && !in_ready.

## Timing
- Reset (rst=1 at an edge):
  - out_valid=0, out_code=0, out_err=0, err_cnt=0.
  - in_ready is 0 while rst is high, and no accept occurs.
- Reset mid-operation: any held, unconsumed result is discarded. rst overrides accept, the output event and clr_cnt.
- Latency: 1 cycle. An input accepted at edge k appears with out_valid=1 after edge k.
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and the block stalls. There is no skid buffer. in_ready depends combinationally on out_ready (documented combinational path).
- The counter updates on the same edge as the accept that carries the error.

## Test plan
- Reset and defaults: assert rst for 2 cycles while driving in_valid=1, in_data=10'h004. Required: out_valid=0, out_code=0, out_err=0, err_cnt=0, in_ready=0, and no accept. After release, in_ready=1.
- Sweep, N=10, strict, out_ready=1: stream 10'h001, 10'h002, ... 10'h200 back-to-back. Required: out_code 0..9, each one cycle after its input, out_err=0, and one result per cycle.
- Illegal inputs, strict: send 10'h000 then 10'h00C. Required: both give out_code=0, out_err=1; err_cnt reaches 2.
- Priority mode (PRIORITY=1, N=16): send 16'h00C then 16'h0000. Required: first gives out_code=2, out_err=0; second gives out_code=0, out_err=1; err_cnt=1.
- Backpressure: hold out_ready=0 with a result 5 held, and drive 10'h100. Required: in_ready=0 and out_code stays 5. Raise out_ready. Required: 5 consumed and 8 accepted on the same edge; out_code=8 the next cycle.
- Counter saturation and clear (CNT_W=2): send 5 illegal words. Required: err_cnt goes 1, 2, 3, 3, 3. Assert clr_cnt together with a sixth illegal accept. Required: err_cnt=0.
